// File: rtl/color_history_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the color_history write-port arbiter.
package color_history_write_arbiter_pkg;
  localparam int CH_ADDR_W       = 19;
  localparam int CH_DATA_W       = 4;
  localparam int CH_NUM_PIXELS   = 307200;
  localparam int CH_STARVE_LIMIT = 8;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ERASE = 2'd2;
endpackage

// File: rtl/color_history_write_arbiter_if.sv
// Camera color-detect write stream (valid/ready) into the write arbiter.
interface color_history_write_arbiter_if #(
  parameter int ADDR_W = color_history_write_arbiter_pkg::CH_ADDR_W,
  parameter int DATA_W = color_history_write_arbiter_pkg::CH_DATA_W
);
  logic              cam_valid;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic              cam_ready;

  modport master (output cam_valid, output cam_addr, output cam_data, input cam_ready);
  modport slave  (input cam_valid, input cam_addr, input cam_data, output cam_ready);
endinterface

// File: rtl/color_history_write_arbiter_erase_gen.sv
// Erase address generator: holds the erase pointer, clamped end address and done pulse.
module color_history_write_arbiter_erase_gen
  import color_history_write_arbiter_pkg::*;
#(
  parameter int ADDR_W     = CH_ADDR_W,
  parameter int NUM_PIXELS = CH_NUM_PIXELS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic              advance,
  input  logic              done_set,
  output logic [ADDR_W-1:0] ptr,
  output logic              last,
  output logic              empty,
  output logic              load_empty,
  output logic              done
);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(NUM_PIXELS - 1);

  logic [ADDR_W-1:0] end_addr;

  function automatic logic [ADDR_W-1:0] clamp_end(input logic [ADDR_W-1:0] a);
    return (a > MAX_ADDR) ? MAX_ADDR : a;
  endfunction

  // Empty ranges (including lo beyond the buffer) are resolved at take-up, never walked.
  assign load_empty = lo > clamp_end(hi);
  assign last       = ptr == end_addr;
  assign empty      = ptr > end_addr;

  always_ff @(posedge clk) begin
    if (load) begin
      ptr      <= lo;
      end_addr <= clamp_end(hi);
    end else if (advance) begin
      ptr <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= done_set;
  end
endmodule

// File: rtl/color_history_write_arbiter.sv
// Shares the color_history write port between the camera stream and the erase engine,
// holding all writes until the buffer's post-reset clear completes.
module color_history_write_arbiter
  import color_history_write_arbiter_pkg::*;
#(
  parameter int ADDR_W       = CH_ADDR_W,
  parameter int DATA_W       = CH_DATA_W,
  parameter int NUM_PIXELS   = CH_NUM_PIXELS,
  parameter int STARVE_LIMIT = CH_STARVE_LIMIT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hist_ready,
  color_history_write_arbiter_if.slave cam,
  input  logic                        erase_start,
  input  logic [ADDR_W-1:0]           erase_lo,
  input  logic [ADDR_W-1:0]           erase_hi,
  output logic                        erase_busy,
  output logic                        erase_done,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [7:0]                  oob_count
);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]        state;
  logic [SW-1:0]     starve_cnt;
  logic              cam_ready_c;
  logic              cam_accept;
  logic              cam_in_range;
  logic              erase_grant;
  logic              erase_load;
  logic              pending;
  logic              pending_empty;
  logic              done_set;
  logic [ADDR_W-1:0] ptr;
  logic              last;
  logic              gen_empty;
  logic              load_empty;

  logic              wr_en_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  color_history_write_arbiter_erase_gen #(
    .ADDR_W     (ADDR_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) u_erase_gen (
    .clk        (clk),
    .reset      (reset),
    .load       (erase_load),
    .lo         (erase_lo),
    .hi         (erase_hi),
    .advance    (erase_grant),
    .done_set   (done_set),
    .ptr        (ptr),
    .last       (last),
    .empty      (gen_empty),
    .load_empty (load_empty),
    .done       (erase_done)
  );

  // Stage p0: arbitration and write selection (combinational)
  assign erase_grant = (state == S_ERASE) && (!cam.cam_valid || starve_cnt == STARVE_MAX);

  always_comb begin
    cam_ready_c = 1'b0;
    case (state)
      S_IDLE:  cam_ready_c = 1'b1;
      S_ERASE: cam_ready_c = !erase_grant;
      default: cam_ready_c = 1'b0;
    endcase
  end

  assign cam.cam_ready  = cam_ready_c;
  assign cam_accept     = cam.cam_valid && cam_ready_c;
  assign cam_in_range   = cam.cam_addr <= MAX_ADDR;
  assign erase_load     = erase_start && !erase_busy && (state != S_ERASE);

  // A command arriving on the same cycle hist_ready rises is taken up directly.
  assign pending        = erase_busy || erase_start;
  assign pending_empty  = erase_busy ? gen_empty : load_empty;

  assign done_set = (erase_grant && last)
                 || ((state == S_INIT) && hist_ready && pending && pending_empty)
                 || ((state == S_IDLE) && erase_start && load_empty);

  assign wr_en_p0   = erase_grant || (cam_accept && cam_in_range);
  assign wr_addr_p0 = erase_grant ? ptr : cam.cam_addr;
  assign wr_data_p0 = erase_grant ? '0 : cam.cam_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      erase_busy <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (erase_load) erase_busy <= 1'b1;
          if (hist_ready) begin
            if (pending && !pending_empty) begin
              state      <= S_ERASE;
              erase_busy <= 1'b1;
              starve_cnt <= '0;
            end else begin
              state      <= S_IDLE;
              erase_busy <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (erase_start) begin
            starve_cnt <= '0;
            if (!load_empty) begin
              state      <= S_ERASE;
              erase_busy <= 1'b1;
            end
          end
        end
        S_ERASE: begin
          if (erase_grant) begin
            starve_cnt <= '0;
            if (last) begin
              state      <= S_IDLE;
              erase_busy <= 1'b0;
            end
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              oob_count <= 8'd0;
    else if (cam_accept && !cam_in_range)   oob_count <= sat_inc8(oob_count);
  end

  // Stage p1: registered write port; address/data hold between writes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_en_p0;
      if (wr_en_p0) begin
        wr_addr <= wr_addr_p0;
        wr_data <= wr_data_p0;
      end
    end
  end
endmodule
